// File: rtl/multiplicador_pkg.sv
`default_nettype none
// ============================================================================
// Module      : multiplicador_pkg
// Description : Shared types for the sequential shift-add multiplier.
// Revision    : 1.0 - initial release
// ============================================================================
package multiplicador_pkg;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    BUSY = 2'd1,
    DONE = 2'd2
  } state_e;

endpackage
`default_nettype wire

// File: rtl/multiplicador_secuencial.sv
`default_nettype none
// ============================================================================
// Module      : multiplicador_secuencial
// Description : Radix-2 shift-add multiplier, signed/unsigned, fixed WIDTH-cycle latency.
// Revision    : 1.0 - initial release
// ============================================================================
module multiplicador_secuencial
  import multiplicador_pkg::*;
#(
  parameter int WIDTH = 8
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               in_valid,
  output logic               in_ready,
  input  logic [WIDTH-1:0]   a,
  input  logic [WIDTH-1:0]   b,
  input  logic               signed_mode,
  output logic               out_valid,
  input  logic               out_ready,
  output logic [2*WIDTH-1:0] c
);

  localparam int CW = $clog2(WIDTH + 1);
  localparam logic [CW-1:0] LAST_STEP = CW'(WIDTH - 1);

  state_e             state_q, state_d;
  logic [CW-1:0]      cnt_q, cnt_d;
  logic [WIDTH-1:0]   mcand_q, mcand_d;
  logic [2*WIDTH-1:0] acc_q, acc_d;
  logic               neg_q, neg_d;

  logic               accept;
  logic [WIDTH-1:0]   mag_a, mag_b;
  logic [WIDTH:0]     sum;
  logic [2*WIDTH-1:0] acc_neg;

  assign accept = in_valid && in_ready;

  // Signed operands are reduced to magnitudes; the most negative value maps to 2**(WIDTH-1).
  assign mag_a = (signed_mode && a[WIDTH-1]) ? (~a + {{(WIDTH-1){1'b0}}, 1'b1}) : a;
  assign mag_b = (signed_mode && b[WIDTH-1]) ? (~b + {{(WIDTH-1){1'b0}}, 1'b1}) : b;

  assign sum = {1'b0, acc_q[2*WIDTH-1:WIDTH]} + {1'b0, (acc_q[0] ? mcand_q : {WIDTH{1'b0}})};
  assign acc_neg = ~acc_q + {{(2*WIDTH-1){1'b0}}, 1'b1};

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= IDLE;
    end else begin
      state_q <= state_d;
    end
  end

  always_comb begin
    state_d = state_q;
    case (state_q)
      IDLE:    if (in_valid)             state_d = BUSY;
      BUSY:    if (cnt_q == LAST_STEP)   state_d = DONE;
      DONE:    if (out_ready)            state_d = IDLE;
      default:                           state_d = IDLE;
    endcase
  end

  always_comb begin
    in_ready  = 1'b0;
    out_valid = 1'b0;
    case (state_q)
      IDLE:    in_ready  = 1'b1;
      DONE:    out_valid = 1'b1;
      default: ;
    endcase
  end

  // Upper half of acc accumulates partial products; lower half holds the shifting multiplier.
  always_comb begin
    cnt_d   = cnt_q;
    mcand_d = mcand_q;
    acc_d   = acc_q;
    neg_d   = neg_q;
    if (accept) begin
      cnt_d   = '0;
      mcand_d = mag_a;
      acc_d   = {{WIDTH{1'b0}}, mag_b};
      neg_d   = signed_mode && (a[WIDTH-1] ^ b[WIDTH-1]);
    end else if (state_q == BUSY) begin
      cnt_d = cnt_q + CW'(1);
      acc_d = {sum, acc_q[WIDTH-1:1]};
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      cnt_q   <= '0;
      mcand_q <= '0;
      acc_q   <= '0;
      neg_q   <= 1'b0;
    end else begin
      cnt_q   <= cnt_d;
      mcand_q <= mcand_d;
      acc_q   <= acc_d;
      neg_q   <= neg_d;
    end
  end

  assign c = out_valid ? (neg_q ? acc_neg : acc_q) : '0;

endmodule
`default_nettype wire

// File: tb/tb_multiplicador_secuencial.sv
`default_nettype none
// ============================================================================
// Module      : tb_multiplicador_secuencial
// Description : Self-checking bench for WIDTH=8 and WIDTH=16 multiplier instances.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_multiplicador_secuencial;

  logic clk = 1'b0;
  logic rst;
  always #5 clk = ~clk;

  logic        v8, s8, or8, ir8, ov8;
  logic [7:0]  a8, b8;
  logic [15:0] c8;
  logic        v16, s16, or16, ir16, ov16;
  logic [15:0] a16, b16;
  logic [31:0] c16;

  multiplicador_secuencial #(.WIDTH(8)) u_dut8 (
    .clk(clk), .rst(rst), .in_valid(v8), .in_ready(ir8), .a(a8), .b(b8),
    .signed_mode(s8), .out_valid(ov8), .out_ready(or8), .c(c8)
  );

  multiplicador_secuencial #(.WIDTH(16)) u_dut16 (
    .clk(clk), .rst(rst), .in_valid(v16), .in_ready(ir16), .a(a16), .b(b16),
    .signed_mode(s16), .out_valid(ov16), .out_ready(or16), .c(c16)
  );

  int n_vec = 0;
  int n_err = 0;

  typedef struct {
    int          w;
    logic [15:0] a;
    logic [15:0] b;
    logic        sm;
    int          bp;
    logic [31:0] want;
  } vec_t;

  vec_t tbl [9];

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] want);
    n_vec++;
    if (act !== want) begin
      n_err++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, want);
    end
  endtask

  function automatic logic get_ir(input int w);
    return (w == 8) ? ir8 : ir16;
  endfunction

  function automatic logic get_ov(input int w);
    return (w == 8) ? ov8 : ov16;
  endfunction

  function automatic logic [31:0] get_c(input int w);
    return (w == 8) ? {16'h0, c8} : c16;
  endfunction

  task automatic drive(input int w, input logic v, input logic [15:0] aa, input logic [15:0] bb,
                       input logic sm, input logic ordy);
    if (w == 8) begin
      v8 = v; a8 = aa[7:0]; b8 = bb[7:0]; s8 = sm; or8 = ordy;
    end else begin
      v16 = v; a16 = aa; b16 = bb; s16 = sm; or16 = ordy;
    end
  endtask

  // Reference: interpret operands as integers of the chosen signedness and multiply.
  function automatic logic [31:0] model(input int w, input logic [15:0] aa, input logic [15:0] bb,
                                        input logic sm);
    longint x, y, p, m;
    m = (longint'(1) << w) - 1;
    x = longint'(aa) & m;
    y = longint'(bb) & m;
    if (sm && aa[w-1]) x = x - (longint'(1) << w);
    if (sm && bb[w-1]) y = y - (longint'(1) << w);
    p = x * y;
    p = p & ((longint'(1) << (2 * w)) - 1);
    return p[31:0];
  endfunction

  // One full transaction: accept, latency, optional backpressure, handshake.
  task automatic do_op(input string tag, input int w, input logic [15:0] aa, input logic [15:0] bb,
                       input logic sm, input int bp, input logic [31:0] want);
    int          lat;
    logic [31:0] got;
    for (int i = 0; i < 100 && !get_ir(w); i++) begin
      @(posedge clk); #1;
    end
    check({tag, " in_ready before accept"}, get_ir(w), 1'b1);
    drive(w, 1'b1, aa, bb, sm, bp == 0);
    @(posedge clk); #1;
    drive(w, 1'b0, ~aa, ~bb, ~sm, bp == 0);
    check({tag, " in_ready after accept"}, get_ir(w), 1'b0);
    lat = 0;
    while (!get_ov(w) && lat < 4 * w + 8) begin
      check({tag, " c zero while busy"}, get_c(w), 32'h0);
      @(posedge clk); #1;
      lat++;
    end
    check({tag, " latency"}, lat, w);
    if (!get_ov(w)) return;
    got = get_c(w);
    check({tag, " product"}, got, want);
    for (int i = 0; i < bp; i++) begin
      @(posedge clk); #1;
      check({tag, " stall out_valid"}, get_ov(w), 1'b1);
      check({tag, " stall c stable"}, get_c(w), got);
      check({tag, " stall in_ready"}, get_ir(w), 1'b0);
    end
    if (bp > 0) drive(w, 1'b0, ~aa, ~bb, ~sm, 1'b1);
    @(posedge clk); #1;
    check({tag, " out_valid after handshake"}, get_ov(w), 1'b0);
    check({tag, " c after handshake"}, get_c(w), 32'h0);
    check({tag, " in_ready after handshake"}, get_ir(w), 1'b1);
  endtask

  int          rw, rbp;
  logic [15:0] ra, rb;
  logic        rsm;

  initial begin
    tbl[0] = '{w: 8,  a: 16'd255,   b: 16'd255,   sm: 1'b0, bp: 0, want: 32'd65025};
    tbl[1] = '{w: 8,  a: 16'h0080,  b: 16'h0080,  sm: 1'b1, bp: 0, want: 32'd16384};
    tbl[2] = '{w: 8,  a: 16'h0080,  b: 16'h007F,  sm: 1'b1, bp: 0, want: 32'h0000C080};
    tbl[3] = '{w: 8,  a: 16'd0,     b: 16'd200,   sm: 1'b0, bp: 0, want: 32'd0};
    tbl[4] = '{w: 8,  a: 16'h00FF,  b: 16'h0001,  sm: 1'b1, bp: 0, want: 32'h0000FFFF};
    tbl[5] = '{w: 8,  a: 16'd7,     b: 16'd9,     sm: 1'b0, bp: 5, want: 32'd63};
    tbl[6] = '{w: 8,  a: 16'h00C8,  b: 16'd0,     sm: 1'b1, bp: 0, want: 32'd0};
    tbl[7] = '{w: 16, a: 16'hFFFF,  b: 16'hFFFF,  sm: 1'b0, bp: 0, want: 32'hFFFE0001};
    tbl[8] = '{w: 16, a: 16'h8000,  b: 16'h8000,  sm: 1'b1, bp: 2, want: 32'h40000000};

    rst = 1'b1;
    drive(8, 1'b0, 16'h0, 16'h0, 1'b0, 1'b1);
    drive(16, 1'b0, 16'h0, 16'h0, 1'b0, 1'b1);
    repeat (3) @(posedge clk);
    #1;
    check("reset out_valid8", ov8, 1'b0);
    check("reset c8", {16'h0, c8}, 32'h0);
    check("reset in_ready8", ir8, 1'b1);
    check("reset out_valid16", ov16, 1'b0);
    check("reset c16", c16, 32'h0);
    rst = 1'b0;

    foreach (tbl[i]) do_op($sformatf("table[%0d]", i), tbl[i].w, tbl[i].a, tbl[i].b, tbl[i].sm,
                           tbl[i].bp, tbl[i].want);

    // Reset three cycles into a 12*13 operation; the aborted product must never appear.
    drive(8, 1'b1, 16'd12, 16'd13, 1'b0, 1'b1);
    @(posedge clk); #1;
    drive(8, 1'b0, 16'd0, 16'd0, 1'b0, 1'b1);
    check("abort accepted", ir8, 1'b0);
    repeat (3) @(posedge clk);
    #1 rst = 1'b1;
    #1;
    check("abort async out_valid", ov8, 1'b0);
    check("abort async in_ready", ir8, 1'b1);
    check("abort async c", {16'h0, c8}, 32'h0);
    @(posedge clk); #1;
    rst = 1'b0;
    do_op("after abort", 8, 16'd3, 16'd4, 1'b0, 0, 32'd12);

    for (int k = 0; k < 2000; k++) begin
      rw  = (k < 1000) ? 8 : 16;
      ra  = 16'($urandom);
      rb  = 16'($urandom);
      if (rw == 8) begin
        ra[15:8] = 8'h0;
        rb[15:8] = 8'h0;
      end
      rsm = 1'($urandom_range(0, 1));
      rbp = ($urandom_range(0, 7) == 0) ? int'($urandom_range(1, 3)) : 0;
      do_op($sformatf("rand%0d w%0d", k, rw), rw, ra, rb, rsm, rbp, model(rw, ra, rb, rsm));
    end

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

  initial begin
    #2ms;
    $display("FAIL watchdog: simulation time limit reached, expected completion");
    $fatal(1, "watchdog");
  end

endmodule
`default_nettype wire
